// File: rtl/hst_ctrl_mc_if.sv
// TRN receive-stream bundle snooped by the host control register decoder.
interface hst_ctrl_mc_if;
  logic [63:0] trn_rd;
  logic [7:0]  trn_rrem_n;
  logic        trn_rsof_n;
  logic        trn_reof_n;
  logic        trn_rsrc_rdy_n;
  logic [6:0]  trn_rbar_hit_n;

  modport master (
    output trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rbar_hit_n
  );
  modport slave (
    input trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rbar_hit_n
  );
endinterface

// File: rtl/hst_ctrl_mc.sv
// Multi-channel host control register decoder: snoops MWr32/MWr64 TLPs on one BAR.
// Optional macro HST_CTRL_OVERRUN_CNT_EN builds the saturating overrun_cnt counter.
module hst_ctrl_mc #(
  parameter int unsigned BARHIT               = 2,
  parameter int unsigned NUM_LBUF             = 2,
  parameter logic [5:0]  BARMP_CPL_ADDR       = 6'h00,
  parameter logic [5:0]  BARMP_LBUF_ADDR_BASE = 6'h08,
  parameter logic [5:0]  BARMP_LBUF_EN_BASE   = 6'h10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  hst_ctrl_mc_if.slave             trn,
  output logic [63:0]              cpl_addr,
  output logic [64*NUM_LBUF-1:0]   lbuf_addr,
  output logic [32*NUM_LBUF-1:0]   lbuf_len,
  output logic [NUM_LBUF-1:0]      lbuf_en,
  input  logic [NUM_LBUF-1:0]      lbuf_dn,
  output logic [NUM_LBUF-1:0]      lbuf_overrun,
  output logic [15:0]              overrun_cnt
);
  localparam int unsigned CH_W     = (NUM_LBUF > 1) ? $clog2(NUM_LBUF) : 1;
  localparam logic [6:0]  FT_MWR32 = 7'b1000000;
  localparam logic [6:0]  FT_MWR64 = 7'b1100000;

  typedef enum logic [2:0] {S_IDLE, S_H32, S_D32, S_H64, S_D64, S_DRAIN} state_t;
  typedef enum logic [1:0] {T_NONE, T_CPL, T_ADDR, T_EN} tgt_t;

  state_t            r_state;
  tgt_t              r_tgt;
  logic [CH_W-1:0]   r_ch;
  logic [9:0]        r_tlp_len;
  logic [31:0]       r_data0;
  logic [63:0]       r_cpl_addr;
  logic [63:0]       r_addr    [NUM_LBUF];
  logic [31:0]       r_buf_len [NUM_LBUF];
  logic [NUM_LBUF-1:0] r_en;
  logic [NUM_LBUF-1:0] r_ovr;

  logic              w_beat, w_sof, w_eof, w_hit, w_len_ok, w_en_go, w_wide_go;
  logic [5:0]        w_off;
  tgt_t              w_tgt;
  logic [CH_W-1:0]   w_ch, w_en_ch;
  logic [31:0]       w_en_val;
  logic [63:0]       w_wide_val;
  logic [NUM_LBUF-1:0] w_en_hit;
  state_t            w_end_st;
  logic              w_unused;

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  assign w_unused = ^{trn.trn_rrem_n, trn.trn_rbar_hit_n};

  // Offset decode (CPL > ADDR > EN) and commit qualification
  always_comb begin
    w_beat   = ~trn.trn_rsrc_rdy_n;
    w_sof    = ~trn.trn_rsof_n;
    w_eof    = ~trn.trn_reof_n;
    w_hit    = ~trn.trn_rbar_hit_n[BARHIT];
    w_end_st = w_eof ? S_IDLE : S_DRAIN;
    w_off    = (r_state == S_H64) ? trn.trn_rd[7:2] : trn.trn_rd[39:34];
    w_tgt    = T_NONE;
    w_ch     = '0;
    if (w_off == BARMP_CPL_ADDR) begin
      w_tgt = T_CPL;
    end else if ({1'b0, w_off} >= {1'b0, BARMP_LBUF_ADDR_BASE} &&
                 {1'b0, w_off} < 7'({1'b0, BARMP_LBUF_ADDR_BASE} + 7'(NUM_LBUF))) begin
      w_tgt = T_ADDR;
      w_ch  = CH_W'(w_off - BARMP_LBUF_ADDR_BASE);
    end else if ({1'b0, w_off} >= {1'b0, BARMP_LBUF_EN_BASE} &&
                 {1'b0, w_off} < 7'({1'b0, BARMP_LBUF_EN_BASE} + 7'(NUM_LBUF))) begin
      w_tgt = T_EN;
      w_ch  = CH_W'(w_off - BARMP_LBUF_EN_BASE);
    end
    case (w_tgt)
      T_CPL, T_ADDR: w_len_ok = (r_tlp_len == 10'd2);
      T_EN:          w_len_ok = (r_tlp_len == 10'd1);
      default:       w_len_ok = 1'b0;
    endcase
    w_en_val = (r_state == S_H32) ? bswap(trn.trn_rd[31:0]) : bswap(trn.trn_rd[63:32]);
    w_en_ch  = (r_state == S_H32) ? w_ch : r_ch;
    w_en_go  = w_beat && (w_en_val != '0) &&
               ((r_state == S_H32 && w_tgt == T_EN && w_len_ok) ||
                (r_state == S_D64 && r_tgt == T_EN));
    w_wide_go  = w_beat && (r_state == S_D32 || r_state == S_D64) &&
                 (r_tgt == T_CPL || r_tgt == T_ADDR);
    w_wide_val = (r_state == S_D32) ? {bswap(trn.trn_rd[63:32]), r_data0}
                                    : {bswap(trn.trn_rd[31:0]), bswap(trn.trn_rd[63:32])};
    for (int i = 0; i < NUM_LBUF; i++) begin
      w_en_hit[i] = w_en_go && (w_en_ch == CH_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tgt      <= T_NONE;
      r_ch       <= '0;
      r_tlp_len  <= '0;
      r_data0    <= '0;
      r_cpl_addr <= '0;
      r_en       <= '0;
      r_ovr      <= '0;
      for (int i = 0; i < NUM_LBUF; i++) begin
        r_addr[i]    <= '0;
        r_buf_len[i] <= '0;
      end
    end else begin
      if (w_beat) begin
        case (r_state)
          S_IDLE: begin
            if (w_sof && w_hit) begin
              r_tlp_len <= trn.trn_rd[41:32];
              case (trn.trn_rd[62:56])
                FT_MWR32: r_state <= S_H32;
                FT_MWR64: r_state <= S_H64;
                default:  r_state <= w_eof ? S_IDLE : S_DRAIN;
              endcase
            end
          end
          S_H32: begin
            if (w_len_ok && w_tgt != T_EN) begin
              r_data0 <= bswap(trn.trn_rd[31:0]);
              r_tgt   <= w_tgt;
              r_ch    <= w_ch;
              r_state <= S_D32;
            end else begin
              r_state <= w_end_st;
            end
          end
          S_H64: begin
            if (w_len_ok) begin
              r_tgt   <= w_tgt;
              r_ch    <= w_ch;
              r_state <= S_D64;
            end else begin
              r_state <= w_end_st;
            end
          end
          S_D32, S_D64: r_state <= w_end_st;
          default:      if (w_eof) r_state <= S_IDLE;
        endcase
      end
      if (w_wide_go && r_tgt == T_CPL) r_cpl_addr <= w_wide_val;
      // A coincident dn frees the channel so a new enable is taken, not flagged
      for (int i = 0; i < NUM_LBUF; i++) begin
        if (w_wide_go && r_tgt == T_ADDR && r_ch == CH_W'(i)) r_addr[i] <= w_wide_val;
        if (w_en_hit[i]) begin
          if (!r_en[i] || lbuf_dn[i]) begin
            r_buf_len[i] <= w_en_val;
            r_en[i]      <= 1'b1;
          end else begin
            r_ovr[i] <= 1'b1;
          end
        end else if (lbuf_dn[i]) begin
          r_en[i] <= 1'b0;
        end
      end
    end
  end

  assign cpl_addr     = r_cpl_addr;
  assign lbuf_en      = r_en;
  assign lbuf_overrun = r_ovr;
  for (genvar g = 0; g < NUM_LBUF; g++) begin : g_pack
    assign lbuf_addr[64*g +: 64] = r_addr[g];
    assign lbuf_len[32*g +: 32]  = r_buf_len[g];
  end

`ifdef HST_CTRL_OVERRUN_CNT_EN
  logic        w_drop;
  logic [15:0] r_ovr_cnt;
  assign w_drop = |(w_en_hit & r_en & ~lbuf_dn);
  always_ff @(posedge clk) begin
    if (!rst_n)                               r_ovr_cnt <= '0;
    else if (w_drop && r_ovr_cnt != 16'hFFFF) r_ovr_cnt <= r_ovr_cnt + 16'd1;
  end
  assign overrun_cnt = r_ovr_cnt;
`else
  assign overrun_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_hst_ctrl_mc.sv
// Randomized + directed bench for hst_ctrl_mc against a TLP-level reference model.
`timescale 1ns/1ps
module tb_hst_ctrl_mc;
  localparam int unsigned NL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [63:0]         cpl_addr;
  logic [64*NL-1:0]    lbuf_addr;
  logic [32*NL-1:0]    lbuf_len;
  logic [NL-1:0]       lbuf_en, lbuf_dn, lbuf_overrun;
  logic [15:0]         overrun_cnt;

  hst_ctrl_mc_if trn_if();

  hst_ctrl_mc #(
    .BARHIT(2), .NUM_LBUF(NL), .BARMP_CPL_ADDR(6'h00),
    .BARMP_LBUF_ADDR_BASE(6'h08), .BARMP_LBUF_EN_BASE(6'h10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trn(trn_if),
    .cpl_addr(cpl_addr), .lbuf_addr(lbuf_addr), .lbuf_len(lbuf_len),
    .lbuf_en(lbuf_en), .lbuf_dn(lbuf_dn), .lbuf_overrun(lbuf_overrun),
    .overrun_cnt(overrun_cnt)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model state
  logic [63:0] m_cpl;
  logic [63:0] m_addr [NL];
  logic [31:0] m_len  [NL];
  logic [NL-1:0] m_en, m_ovr;
  logic [15:0] m_cnt;

  function automatic logic [31:0] sw(input logic [31:0] v);
    return {<<8{v}};
  endfunction

  task automatic model_reset();
    m_cpl = '0; m_en = '0; m_ovr = '0; m_cnt = '0;
    for (int i = 0; i < NL; i++) begin m_addr[i] = '0; m_len[i] = '0; end
  endtask

  // Effect of one complete TLP (and dn mask seen on its last beat)
  task automatic model_write(input logic [5:0] off, input int len, input logic [31:0] v0,
                             input logic [31:0] v1, input bit ok, input logic [NL-1:0] dn);
    int o;
    logic [NL-1:0] hit;
    o = int'(off);
    hit = '0;
    if (ok) begin
      if (o == 0) begin
        if (len == 2) m_cpl = {v1, v0};
      end else if (o >= 8 && o < 8 + NL) begin
        if (len == 2) m_addr[o-8] = {v1, v0};
      end else if (o >= 16 && o < 16 + NL) begin
        if (len == 1 && v0 != 0) begin
          hit[o-16] = 1'b1;
          if (!m_en[o-16] || dn[o-16]) begin
            m_len[o-16] = v0;
            m_en[o-16]  = 1'b1;
          end else begin
            m_ovr[o-16] = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          end
        end
      end
    end
    for (int i = 0; i < NL; i++) if (dn[i] && !hit[i]) m_en[i] = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [64*NL-1:0] ea;
    logic [32*NL-1:0] el;
    logic [15:0] ec;
    for (int i = 0; i < NL; i++) begin
      ea[64*i +: 64] = m_addr[i];
      el[32*i +: 32] = m_len[i];
    end
`ifdef HST_CTRL_OVERRUN_CNT_EN
    ec = m_cnt;
`else
    ec = 16'h0000;
`endif
    chk($sformatf("%s.cpl", tag),  128'(cpl_addr),     128'(m_cpl));
    chk($sformatf("%s.addr", tag), 128'(lbuf_addr),    128'(ea));
    chk($sformatf("%s.len", tag),  128'(lbuf_len),     128'(el));
    chk($sformatf("%s.en", tag),   128'(lbuf_en),      128'(m_en));
    chk($sformatf("%s.ovr", tag),  128'(lbuf_overrun), 128'(m_ovr));
    chk($sformatf("%s.cnt", tag),  128'(overrun_cnt),  128'(ec));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_junk();
    trn_if.trn_rsrc_rdy_n = 1'b1;
    trn_if.trn_rd         = {$urandom, $urandom};
    trn_if.trn_rsof_n     = 1'($urandom);
    trn_if.trn_reof_n     = 1'($urandom);
    cyc();
  endtask

  task automatic beat(input logic [63:0] d, input bit sof, input bit eof, input bit gaps,
                      input logic [NL-1:0] dn);
    if (gaps) repeat ($urandom_range(0, 2)) idle_junk();
    trn_if.trn_rsrc_rdy_n = 1'b0;
    trn_if.trn_rd         = d;
    trn_if.trn_rsof_n     = !sof;
    trn_if.trn_reof_n     = !eof;
    lbuf_dn               = dn;
    cyc();
    lbuf_dn               = '0;
    trn_if.trn_rsrc_rdy_n = 1'b1;
    trn_if.trn_rsof_n     = 1'b1;
    trn_if.trn_reof_n     = 1'b1;
  endtask

  task automatic tlp32(input logic [5:0] off, input int len, input logic [31:0] v0,
                       input logic [31:0] v1, input bit gaps, input bit ok,
                       input logic [NL-1:0] dn);
    logic [31:0] dw0;
    dw0 = {1'b0, 7'b1000000, 14'h0, 10'(len)};
    trn_if.trn_rbar_hit_n = ok ? 7'b1111011 : 7'b1111111;
    beat({dw0, 32'($urandom)}, 1'b1, 1'b0, gaps, '0);
    beat({24'($urandom), off, 2'b00, sw(v0)}, 1'b0, len == 1, gaps, (len == 1) ? dn : '0);
    if (len != 1) beat({sw(v1), 32'($urandom)}, 1'b0, 1'b1, gaps, dn);
    model_write(off, len, v0, v1, ok, dn);
  endtask

  task automatic tlp64(input logic [5:0] off, input int len, input logic [31:0] v0,
                       input logic [31:0] v1, input bit gaps, input bit ok,
                       input logic [NL-1:0] dn);
    logic [31:0] dw0;
    dw0 = {1'b0, 7'b1100000, 14'h0, 10'(len)};
    trn_if.trn_rbar_hit_n = ok ? 7'b1111011 : 7'b1111111;
    beat({dw0, 32'($urandom)}, 1'b1, 1'b0, gaps, '0);
    beat({32'($urandom), 24'($urandom), off, 2'b00}, 1'b0, 1'b0, gaps, '0);
    beat({sw(v0), sw(v1)}, 1'b0, 1'b1, gaps, dn);
    model_write(off, len, v0, v1, ok, dn);
  endtask

  task automatic tlp_raw(input logic [6:0] ft, input int nbeats, input bit ok);
    trn_if.trn_rbar_hit_n = ok ? 7'b1111011 : 7'b1111111;
    beat({1'b0, ft, 14'h0, 10'd1, 24'($urandom), 6'h10, 2'b00}, 1'b1, nbeats == 1, 1'b1, '0);
    for (int b = 1; b < nbeats; b++)
      beat({$urandom, $urandom}, 1'b0, b == nbeats - 1, 1'b1, '0);
  endtask

  task automatic dn_pulse(input logic [NL-1:0] m);
    lbuf_dn = m;
    cyc();
    lbuf_dn = '0;
    m_en = m_en & ~m;
  endtask

  logic [5:0] offs [8] = '{6'h00, 6'h08, 6'h09, 6'h10, 6'h11, 6'h01, 6'h0A, 6'h12};

  initial begin
    logic [5:0]  off;
    logic [31:0] v0, v1;
    int          len;
    logic [15:0] exp_cnt;

    rst_n = 1'b0;
    lbuf_dn = '0;
    trn_if.trn_rd = '0; trn_if.trn_rrem_n = '0;
    trn_if.trn_rsof_n = 1'b1; trn_if.trn_reof_n = 1'b1;
    trn_if.trn_rsrc_rdy_n = 1'b1; trn_if.trn_rbar_hit_n = 7'h7F;
    model_reset();
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    check_all("reset");

    // MWr32 address write to channel 0
    tlp32(6'h08, 2, 32'h0000_1000, 32'h0, 1'b0, 1'b1, '0);
    chk("tp1_addr0", 128'(lbuf_addr[63:0]), 128'(64'h0000_0000_0000_1000));
    check_all("tp1");

    // MWr64 enable on channel 1, then retire
    tlp64(6'h11, 1, 32'h0000_0800, 32'h0, 1'b0, 1'b1, '0);
    chk("tp2_len1", 128'(lbuf_len[63:32]), 128'(32'h0000_0800));
    chk("tp2_en1", 128'(lbuf_en[1]), 128'(1'b1));
    dn_pulse(2'b10);
    chk("tp2_dn_en1", 128'(lbuf_en[1]), 128'(1'b0));
    check_all("tp2");

    // Enable while armed is dropped and flagged
    tlp32(6'h10, 1, 32'h0000_0100, 32'h0, 1'b0, 1'b1, '0);
    tlp64(6'h10, 1, 32'h0000_0055, 32'h0, 1'b0, 1'b1, '0);
`ifdef HST_CTRL_OVERRUN_CNT_EN
    exp_cnt = 16'd1;
`else
    exp_cnt = 16'd0;
`endif
    chk("tp3_en0", 128'(lbuf_en[0]), 128'(1'b1));
    chk("tp3_len0", 128'(lbuf_len[31:0]), 128'(32'h0000_0100));
    chk("tp3_ovr0", 128'(lbuf_overrun[0]), 128'(1'b1));
    chk("tp3_cnt", 128'(overrun_cnt), 128'(exp_cnt));

    // Enable coincident with dn, then zero-length enables
    tlp32(6'h10, 1, 32'h0000_0200, 32'h0, 1'b0, 1'b1, 2'b01);
    chk("tp4_en0", 128'(lbuf_en[0]), 128'(1'b1));
    chk("tp4_len0", 128'(lbuf_len[31:0]), 128'(32'h0000_0200));
    tlp32(6'h10, 1, 32'h0, 32'h0, 1'b0, 1'b1, '0);
    tlp64(6'h11, 1, 32'h0, 32'h0, 1'b0, 1'b1, '0);
    chk("tp4_zero_en", 128'(lbuf_en), 128'(2'b01));
    chk("tp4_zero_ovr", 128'(lbuf_overrun), 128'(2'b01));
    check_all("tp4");

    // Malformed / foreign TLPs with valid-gaps
    tlp32(6'h10, 2, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1, '0);
    tlp_raw(7'b1000000, 5, 1'b0);
    tlp_raw(7'b1001010, 3, 1'b1);
    check_all("robust");
    tlp32(6'h00, 2, 32'hDEAD_BEEF, 32'h0000_00C0, 1'b1, 1'b1, '0);
    chk("robust_cpl", 128'(cpl_addr), 128'(64'h0000_00C0_DEAD_BEEF));

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      off = ($urandom_range(0, 4) == 0) ? 6'($urandom) : offs[$urandom_range(0, 7)];
      len = $urandom_range(1, 3);
      v0  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      v1  = $urandom;
      if ($urandom_range(0, 1) == 0)
        tlp32(off, len, v0, v1, 1'b1, $urandom_range(0, 9) != 0, '0);
      else
        tlp64(off, len, v0, v1, 1'b1, $urandom_range(0, 9) != 0, '0);
      if ($urandom_range(0, 2) == 0) dn_pulse(NL'($urandom));
      check_all($sformatf("rnd%0d", t));
    end

    // Reset during the D64 beat of an address write
    trn_if.trn_rbar_hit_n = 7'b1111011;
    beat({1'b0, 7'b1100000, 14'h0, 10'd2, 32'h0}, 1'b1, 1'b0, 1'b0, '0);
    beat({32'h0, 24'h0, 6'h09, 2'b00}, 1'b0, 1'b0, 1'b0, '0);
    trn_if.trn_rsrc_rdy_n = 1'b0;
    trn_if.trn_rd = {sw(32'hAAAA_5555), sw(32'h1111_2222)};
    trn_if.trn_reof_n = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    trn_if.trn_rsrc_rdy_n = 1'b1;
    trn_if.trn_reof_n = 1'b1;
    model_reset();
    chk("rst_mid_cpl", 128'(cpl_addr), 128'(64'h0));
    check_all("rst_mid");
    beat({sw(32'hAAAA_5555), sw(32'h1111_2222)}, 1'b0, 1'b1, 1'b0, '0);
    check_all("rst_tail");
    tlp64(6'h09, 2, 32'h0BAD_F00D, 32'h0000_0001, 1'b1, 1'b1, '0);
    chk("post_rst_addr1", 128'(lbuf_addr[127:64]), 128'(64'h0000_0001_0BAD_F00D));
    check_all("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
